// File: rtl/lsu_dcache_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lsu_dcache_sched : arbitrates the single dcache port, committed stores   |
// | first, loads otherwise; one outstanding request at a time.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lsu_dcache_sched #(
  parameter int ROB_ADDR_WIDTH = 5,
  parameter int LD_TAG_WIDTH   = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sq_deq_ready,
  input  logic [31:0]               sq_head_addr,
  input  logic [3:0]                sq_head_wmask,
  input  logic [31:0]               sq_head_wdata,
  input  logic [ROB_ADDR_WIDTH-1:0] sq_head_rob,
  input  logic [ROB_ADDR_WIDTH-1:0] rob_head,
  input  logic                      rob_head_valid,
  output logic                      sq_deq_req,
  output logic                      store_done,
  output logic [ROB_ADDR_WIDTH-1:0] store_done_rob,
  input  logic                      ld_valid,
  input  logic [31:0]               ld_addr,
  input  logic [3:0]                ld_rmask,
  input  logic [LD_TAG_WIDTH-1:0]   ld_tag,
  output logic                      ld_ready,
  output logic                      ld_resp_valid,
  output logic [LD_TAG_WIDTH-1:0]   ld_resp_tag,
  output logic [31:0]               ld_resp_rdata,
  input  logic                      flush,
  output logic [31:0]               dmem_addr,
  output logic [3:0]                dmem_rmask,
  output logic [3:0]                dmem_wmask,
  output logic [31:0]               dmem_wdata,
  input  logic [31:0]               dmem_rdata,
  input  logic                      dmem_resp,
  output logic [CNT_WIDTH-1:0]      perf_ld_cnt,
  output logic [CNT_WIDTH-1:0]      perf_st_cnt
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] LOAD_WAIT  = 2'd1;
  localparam logic [1:0] STORE_WAIT = 2'd2;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]                state_q, state_d;
  logic [31:0]               addr_q, addr_d;
  logic [31:0]               wdata_q, wdata_d;
  logic [3:0]                rmask_q, rmask_d;
  logic [3:0]                wmask_q, wmask_d;
  logic [LD_TAG_WIDTH-1:0]   tag_q, tag_d;
  logic [ROB_ADDR_WIDTH-1:0] rob_q, rob_d;
  logic                      drop_q, drop_d;
  logic [CNT_WIDTH-1:0]      ld_cnt_q, ld_cnt_d;
  logic [CNT_WIDTH-1:0]      st_cnt_q, st_cnt_d;
  logic                      st_ok;

  // Only a store whose ROB entry is at the head (i.e. committing) may write.
  assign st_ok = sq_deq_ready && rob_head_valid && (sq_head_rob == rob_head);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rmask_q  <= '0;
      wmask_q  <= '0;
      tag_q    <= '0;
      rob_q    <= '0;
      drop_q   <= 1'b0;
      ld_cnt_q <= '0;
      st_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rmask_q  <= rmask_d;
      wmask_q  <= wmask_d;
      tag_q    <= tag_d;
      rob_q    <= rob_d;
      drop_q   <= drop_d;
      ld_cnt_q <= ld_cnt_d;
      st_cnt_q <= st_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rmask_d = rmask_q;
    wmask_d = wmask_q;
    tag_d   = tag_q;
    rob_d   = rob_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (st_ok) begin
          addr_d  = sq_head_addr;
          wmask_d = sq_head_wmask;
          wdata_d = sq_head_wdata;
          rob_d   = sq_head_rob;
          rmask_d = '0;
          state_d = STORE_WAIT;
        end else if (ld_valid && !flush) begin
          addr_d  = ld_addr;
          rmask_d = ld_rmask;
          tag_d   = ld_tag;
          wmask_d = '0;
          state_d = LOAD_WAIT;
        end
      end
      LOAD_WAIT: begin
        // A flushed load still owns the port; its response is swallowed.
        if (dmem_resp) begin
          rmask_d = '0;
          drop_d  = 1'b0;
          state_d = IDLE;
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      STORE_WAIT: begin
        if (dmem_resp) begin
          wmask_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        rmask_d = '0;
        wmask_d = '0;
        drop_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    ld_cnt_d = ld_cnt_q;
    st_cnt_d = st_cnt_q;
    if (ld_resp_valid && (ld_cnt_q != '1)) ld_cnt_d = ld_cnt_q + CNT_ONE;
    if (store_done && (st_cnt_q != '1))    st_cnt_d = st_cnt_q + CNT_ONE;
  end

  always_comb begin
    ld_ready      = 1'b0;
    ld_resp_valid = 1'b0;
    sq_deq_req    = 1'b0;
    store_done    = 1'b0;
    case (state_q)
      IDLE:       ld_ready      = !rst && !st_ok && ld_valid && !flush;
      LOAD_WAIT:  ld_resp_valid = !rst && dmem_resp && !drop_q && !flush;
      STORE_WAIT: begin
        store_done = !rst && dmem_resp;
        sq_deq_req = !rst && dmem_resp;
      end
      default: ;
    endcase
    ld_resp_tag    = ld_resp_valid ? tag_q : '0;
    ld_resp_rdata  = ld_resp_valid ? dmem_rdata : '0;
    store_done_rob = store_done ? rob_q : '0;
  end

  assign dmem_addr   = addr_q;
  assign dmem_rmask  = rmask_q;
  assign dmem_wmask  = wmask_q;
  assign dmem_wdata  = wdata_q;
  assign perf_ld_cnt = ld_cnt_q;
  assign perf_st_cnt = st_cnt_q;

endmodule
`default_nettype wire

// File: doc/lsu_dcache_sched.md
Name: lsu_dcache_sched

Overview:
- Schedules the single data-cache port between the load path and the store queue head.
- A store issues only when its ROB entry is at the ROB head, i.e. it is committing. Committed stores always win the port over loads.
- The store-queue entry is dequeued only after the cache acknowledges the write, so the entry stays visible for address checks until memory is updated.
- Sits between store_queue / load issue logic and the dcache request/response interface.

Parameters:
- ROB_ADDR_WIDTH, 5, width of ROB index.
- LD_TAG_WIDTH, 5, width of load destination tag returned with load data.
- CNT_WIDTH, 16, width of saturating performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- sq_deq_ready  in  1  store queue non-empty
- sq_head_addr  in  32  head store byte address
- sq_head_wmask  in  4  head store byte mask
- sq_head_wdata  in  32  head store data
- sq_head_rob  in  ROB_ADDR_WIDTH  head store ROB index
- rob_head  in  ROB_ADDR_WIDTH  current ROB head index
- rob_head_valid  in  1  ROB non-empty
- sq_deq_req  out  1  pop store queue head
- store_done  out  1  store write acknowledged
- store_done_rob  out  ROB_ADDR_WIDTH  ROB index of the completed store
- ld_valid  in  1  load request valid
- ld_addr  in  32  load address
- ld_rmask  in  4  load byte mask
- ld_tag  in  LD_TAG_WIDTH  load tag
- ld_ready  out  1  load accepted this cycle
- ld_resp_valid  out  1  load data valid
- ld_resp_tag  out  LD_TAG_WIDTH  tag of the returned load
- ld_resp_rdata  out  32  load data
- flush  in  1  pipeline flush (branch mispredict)
- dmem_addr  out  32  cache address
- dmem_rmask  out  4  cache read mask
- dmem_wmask  out  4  cache write mask
- dmem_wdata  out  32  cache write data
- dmem_rdata  in  32  cache read data
- dmem_resp  in  1  cache response
- perf_ld_cnt  out  CNT_WIDTH  loads completed, not dropped
- perf_st_cnt  out  CNT_WIDTH  stores completed

Behaviour:
- FSM states: IDLE, LOAD_WAIT, STORE_WAIT.
- Reset: state IDLE; all dmem_* outputs 0; all handshake and response outputs 0; drop flag 0; counters 0.
- Store eligibility (st_ok), combinational: sq_deq_ready && rob_head_valid && sq_head_rob == rob_head.

IDLE:
- If st_ok: capture the store's addr/wmask/wdata/rob into request registers; next state STORE_WAIT. ld_ready=0.
- Else if ld_valid && !flush: ld_ready=1 this cycle; capture addr/rmask/tag; next state LOAD_WAIT.
- Else stay IDLE.
- st_ok outranks a flush: a committing store is never flushed.

Request timing:
- dmem_* outputs are driven only from registers. Masks are nonzero only in LOAD_WAIT or STORE_WAIT, and only one of rmask/wmask is nonzero at a time.
- dmem request appears exactly 1 cycle after the IDLE decision.
- Request held stable until and including the dmem_resp cycle.

LOAD_WAIT:
- On dmem_resp: ld_resp_valid=1 in that same cycle, with ld_resp_rdata=dmem_rdata and the captured tag, unless the drop flag is set or flush is high that cycle. Next state IDLE.
- flush in LOAD_WAIT sets the drop flag. The request is not cancelled; the response is consumed silently.
- Drop flag clears on the return to IDLE.

STORE_WAIT:
- On dmem_resp: sq_deq_req=1, store_done=1, store_done_rob=captured ROB index, all combinational in the resp cycle. Next state IDLE.
- flush has no effect in STORE_WAIT.

General rules:
- After every response there is at least one IDLE cycle, so back-to-back issue spacing is resp cycle + 1 decide cycle + request cycle.
- ld_ready, ld_resp_valid, sq_deq_req and store_done are single-cycle pulses.
- dmem_resp while in IDLE is ignored.
- Counters increment on store_done and on non-dropped ld_resp_valid, saturating at all-ones.
- rst asserted in any state: next cycle is IDLE with all outputs at reset values. An in-flight cache response is ignored.

Test Plan:
- Load only: ld_valid, addr 0x100, rmask 0xF, tag 3 in IDLE.
  - ld_ready pulses at cycle T.
  - dmem_rmask=0xF, addr=0x100 at T+1.
  - dmem_resp at T+3 with rdata 0xDEADBEEF → ld_resp_valid, tag 3, rdata 0xDEADBEEF at T+3; perf_ld_cnt=1.
- Store commit: sq head rob 7, rob_head 7, addr 0x200, wmask 0x3, wdata 0x1234.
  - dmem_wmask=0x3 next cycle.
  - On dmem_resp: sq_deq_req=1, store_done=1, store_done_rob=7.
  - sq_deq_req never asserted before dmem_resp.
- Priority: st_ok and ld_valid in the same IDLE cycle → store issued, ld_ready=0; load accepted in the first IDLE cycle after the store completes.
- Non-head store: sq head rob 9, rob_head 8, no load → no dmem request.
  - Advance rob_head to 9 → store issues 1 cycle later.
- Flush:
  - flush in LOAD_WAIT → response consumed, ld_resp_valid stays 0, perf_ld_cnt unchanged.
  - flush in the IDLE cycle with ld_valid and !st_ok → ld_ready=0.
  - flush during STORE_WAIT → store_done still pulses.
- Reset mid-STORE_WAIT → all dmem masks 0 next cycle; a late dmem_resp produces no sq_deq_req or store_done.
